// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: two-lane transmit serializer.
// Buffers a valid/ready byte stream in a small FIFO, stripes bytes
// alternately across two lanes and shifts each lane out MSB-first, one byte
// per 8-cycle frame. Sends COMMA frames for post-reset sync and when idle.
//
// Optional feature: define PHY_TX_IDLE_COUNT_EN to add idle_cnt_out, a
// saturating count of ACTIVE frames in which both lanes carried COMMA.
//
// Ports:
//   clk_8f       bit-rate clock, rising edge
//   reset        asynchronous active-low reset
//   data_in      payload byte
//   valid_in     data_in valid
//   ready_out    byte accepted this cycle when valid_in is high
//   data_out0    lane 0 serial bit
//   data_out1    lane 1 serial bit
//   active_out   sync phase complete, payload path open
//   idle_cnt_out (PHY_TX_IDLE_COUNT_EN only) idle frame count
module phy_tx_serializer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_FRAMES = 4,
    parameter logic [7:0]  COMMA       = 8'hBC
) (
    input  logic        clk_8f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out0,
    output logic        data_out1,
    output logic        active_out
`ifdef PHY_TX_IDLE_COUNT_EN
    ,
    output logic [15:0] idle_cnt_out
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SYNC_W = $clog2(SYNC_FRAMES + 1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         sr0_q, sr0_d;
    logic [7:0]         sr1_q, sr1_d;
    logic               sel_q, sel_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               active_q;
    logic [7:0]         mem [FIFO_DEPTH];
`ifdef PHY_TX_IDLE_COUNT_EN
    logic [15:0]        idle_q, idle_d;
`endif

    logic               boundary_c;
    logic               push_c;
    logic [1:0]         pop_c;
    logic [7:0]         head_c, head1_c;

    assign boundary_c = (bit_cnt_q == 3'd7);
    assign push_c     = valid_in && ready_q;
    assign head_c     = mem[rd_ptr_q];
    assign head1_c    = mem[rd_ptr_q + PTR_W'(1)];

    // Frame-boundary lane loading, sync sequencing and FIFO bookkeeping
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        sr0_d   = {sr0_q[6:0], 1'b0};
        sr1_d   = {sr1_q[6:0], 1'b0};
        sel_d   = sel_q;
        pop_c   = 2'd0;
`ifdef PHY_TX_IDLE_COUNT_EN
        idle_d  = idle_q;
`endif
        if (boundary_c) begin
            case (state_q)
                ST_SYNC: begin
                    sr0_d  = COMMA;
                    sr1_d  = COMMA;
                    sync_d = sync_q + SYNC_W'(1);
                    if (sync_q == SYNC_W'(SYNC_FRAMES - 1)) begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    if (count_q >= CNT_W'(2)) begin
                        // Lane sel always carries the older byte
                        sr0_d = sel_q ? head1_c : head_c;
                        sr1_d = sel_q ? head_c  : head1_c;
                        pop_c = 2'd2;
                    end else if (count_q == CNT_W'(1)) begin
                        sr0_d = sel_q ? COMMA  : head_c;
                        sr1_d = sel_q ? head_c : COMMA;
                        pop_c = 2'd1;
                        sel_d = ~sel_q;
                    end else begin
                        sr0_d = COMMA;
                        sr1_d = COMMA;
`ifdef PHY_TX_IDLE_COUNT_EN
                        if (idle_q != 16'hFFFF) begin
                            idle_d = idle_q + 16'd1;
                        end
`endif
                    end
                end
            endcase
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        ready_d = (state_d == ST_ACTIVE) && (count_d != CNT_W'(FIFO_DEPTH));
    end

    // State and datapath registers
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SYNC;
            sync_q    <= '0;
            bit_cnt_q <= 3'd0;
            sr0_q     <= COMMA;
            sr1_q     <= COMMA;
            sel_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            active_q  <= 1'b0;
`ifdef PHY_TX_IDLE_COUNT_EN
            idle_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            sr0_q     <= sr0_d;
            sr1_q     <= sr1_d;
            sel_q     <= sel_d;
            rd_ptr_q  <= rd_ptr_q + PTR_W'(pop_c);
            wr_ptr_q  <= wr_ptr_q + PTR_W'(push_c);
            count_q   <= count_d;
            ready_q   <= ready_d;
            active_q  <= (state_d == ST_ACTIVE);
`ifdef PHY_TX_IDLE_COUNT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    // FIFO storage; stale contents are unreachable after reset via pointers
    always_ff @(posedge clk_8f) begin
        if (push_c) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out0  = sr0_q[7];
    assign data_out1  = sr1_q[7];
    assign ready_out  = ready_q;
    assign active_out = active_q;
`ifdef PHY_TX_IDLE_COUNT_EN
    assign idle_cnt_out = idle_q;
`endif

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed self-checking bench for phy_tx_serializer.
module tb_phy_tx_serializer;

    localparam logic [7:0] COMMA = 8'hBC;

    logic        clk_8f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_out;
    logic        data_out0;
    logic        data_out1;
    logic        active_out;
`ifdef PHY_TX_IDLE_COUNT_EN
    logic [15:0] idle_cnt_out;
`endif

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    phy_tx_serializer dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .active_out (active_out)
`ifdef PHY_TX_IDLE_COUNT_EN
        ,
        .idle_cnt_out (idle_cnt_out)
`endif
    );

    always #5 clk_8f = ~clk_8f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_8f);
        #1;
        edge_n++;
    endtask

    task automatic tick_to_boundary();
        tick();
        while (edge_n % 8 != 0) tick();
    endtask

    // Observes one frame starting just after a boundary; optionally pushes one byte on its first edge
    task automatic capture_frame(input logic drive_push, input logic [7:0] push_data,
                                 output logic [7:0] l0, output logic [7:0] l1);
        l0 = 8'h00;
        l1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            l0 = {l0[6:0], data_out0};
            l1 = {l1[6:0], data_out1};
            if (drive_push) begin
                valid_in = (i == 0);
                data_in  = push_data;
            end
            tick();
        end
        if (drive_push) valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] l0, l1;
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(posedge clk_8f);
        #1;
        total++;
        if ({data_out0, data_out1} !== 2'b11) begin
            bad++; $display("FAIL reset_lanes: got %b expected 11", {data_out0, data_out1});
        end
        total++;
        if ({ready_out, active_out} !== 2'b00) begin
            bad++; $display("FAIL reset_ready_active: got %b expected 00", {ready_out, active_out});
        end
        reset  = 1'b1;
        edge_n = 0;
        for (int f = 0; f < 3; f++) begin
            capture_frame(1'b0, 8'h00, l0, l1);
            total++;
            if (l0 !== COMMA || l1 !== COMMA) begin
                bad++; $display("FAIL sync_frame%0d: got %h/%h expected bc/bc", f, l0, l1);
            end
        end
        repeat (7) tick();
        total++;
        if ({active_out, ready_out} !== 2'b00) begin
            bad++; $display("FAIL active_early edge31: got %b expected 00", {active_out, ready_out});
        end
        tick();
        total++;
        if ({active_out, ready_out} !== 2'b11) begin
            bad++; $display("FAIL active_rise edge32: got %b expected 11", {active_out, ready_out});
        end
    endtask

    task automatic test_burst();
        logic [7:0] vec [4];
        logic [7:0] l0, l1;
        logic [7:0] exp0 [3];
        logic [7:0] exp1 [3];
        vec  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp0 = '{8'h11, 8'h33, COMMA};
        exp1 = '{8'h22, 8'h44, COMMA};
        for (int b = 0; b < 4; b++) begin
            valid_in = 1'b1;
            data_in  = vec[b];
            tick();
        end
        valid_in = 1'b0;
        total++;
        if (ready_out !== 1'b0) begin
            bad++; $display("FAIL burst_full_ready: got %b expected 0", ready_out);
        end
        tick_to_boundary();
        for (int f = 0; f < 3; f++) begin
            capture_frame(1'b0, 8'h00, l0, l1);
            total++;
            if (l0 !== exp0[f] || l1 !== exp1[f]) begin
                bad++; $display("FAIL burst_frame%0d: got %h/%h expected %h/%h", f, l0, l1, exp0[f], exp1[f]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] l0, l1;
        capture_frame(1'b1, 8'h5A, l0, l1);
        total++;
        if (l0 !== COMMA || l1 !== COMMA) begin
            bad++; $display("FAIL single_pre: got %h/%h expected bc/bc", l0, l1);
        end
        capture_frame(1'b1, 8'hA5, l0, l1);
        total++;
        if (l0 !== 8'h5A || l1 !== COMMA) begin
            bad++; $display("FAIL single_k: got %h/%h expected 5a/bc", l0, l1);
        end
        capture_frame(1'b0, 8'h00, l0, l1);
        total++;
        if (l0 !== COMMA || l1 !== 8'hA5) begin
            bad++; $display("FAIL single_k1: got %h/%h expected bc/a5", l0, l1);
        end
        capture_frame(1'b0, 8'h00, l0, l1);
        total++;
        if (l0 !== COMMA || l1 !== COMMA) begin
            bad++; $display("FAIL single_idle: got %h/%h expected bc/bc", l0, l1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp0 [7];
        logic [7:0] exp1 [7];
        exp0 = '{COMMA, 8'h01, 8'h03, 8'h05, 8'h07, 8'h09, COMMA};
        exp1 = '{COMMA, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, COMMA};
        fork
            begin : drv
                int   idx;
                int   drop_at;
                int   guard;
                logic r;
                idx     = 0;
                drop_at = -1;
                guard   = 0;
                while (idx < 10 && guard < 200) begin
                    valid_in = 1'b1;
                    data_in  = 8'(idx + 1);
                    r = ready_out;
                    if (!r && drop_at < 0) drop_at = idx;
                    @(posedge clk_8f);
                    #1;
                    if (r) idx++;
                    guard++;
                end
                valid_in = 1'b0;
                total++;
                if (idx != 10) begin
                    bad++; $display("FAIL stream_timeout: pushed %0d expected 10", idx);
                end
                total++;
                if (drop_at != 4) begin
                    bad++; $display("FAIL stream_ready_drop: dropped after %0d pushes expected 4", drop_at);
                end
            end
            begin : mon
                logic [7:0] l0, l1;
                for (int f = 0; f < 7; f++) begin
                    capture_frame(1'b0, 8'h00, l0, l1);
                    total++;
                    if (l0 !== exp0[f] || l1 !== exp1[f]) begin
                        bad++; $display("FAIL stream_frame%0d: got %h/%h expected %h/%h", f, l0, l1, exp0[f], exp1[f]);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] l0, l1;
        for (int b = 0; b < 3; b++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'hC0 + b);
            tick();
        end
        valid_in = 1'b0;
        reset    = 1'b0;
        #1;
        total++;
        if ({data_out0, data_out1, ready_out, active_out} !== 4'b1100) begin
            bad++; $display("FAIL midreset_outputs: got %b expected 1100", {data_out0, data_out1, ready_out, active_out});
        end
`ifdef PHY_TX_IDLE_COUNT_EN
        total++;
        if (idle_cnt_out !== 16'd0) begin
            bad++; $display("FAIL midreset_idle: got %0d expected 0", idle_cnt_out);
        end
`endif
        repeat (2) @(posedge clk_8f);
        #1;
        reset  = 1'b1;
        edge_n = 0;
        for (int f = 0; f < 4; f++) begin
            capture_frame(1'b0, 8'h00, l0, l1);
            total++;
            if (l0 !== COMMA || l1 !== COMMA) begin
                bad++; $display("FAIL resync_frame%0d: got %h/%h expected bc/bc", f, l0, l1);
            end
        end
        total++;
        if (active_out !== 1'b1) begin
            bad++; $display("FAIL resync_active: got %b expected 1", active_out);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame(1'b0, 8'h00, l0, l1);
            total++;
            if (l0 !== COMMA || l1 !== COMMA) begin
                bad++; $display("FAIL stale_frame%0d: got %h/%h expected bc/bc", f, l0, l1);
            end
        end
    endtask

`ifdef PHY_TX_IDLE_COUNT_EN
    task automatic test_idle_count();
        // Idle ACTIVE boundaries at edges 40 and 48 already passed; run to edge 112
        while (edge_n < 112) tick();
        total++;
        if (idle_cnt_out !== 16'd10) begin
            bad++; $display("FAIL idle_count: got %0d expected 10", idle_cnt_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PHY_TX_IDLE_COUNT_EN
        test_idle_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
